// File: rtl/double_buffer_clear_ram.sv
// Two-bank RAM with a background sweeper that clears the shadow bank after every swap,
// so a freshly activated bank always starts out filled with CLEAR_VALUE.
module double_buffer_clear_ram #(
  parameter int                    DATA_WIDTH  = 1,
  parameter int                    DEPTH       = 1024,
  parameter int                    ADDR_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  active_bank,
  output logic                  clear_done,
  output logic                  ready
);

  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    CLEARING = 2'd1,
    CLEAN    = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] sweep, sweep_next;
  logic                  active_next;
  logic                  pending, pending_next;
  logic                  ack_next;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [IDX_W-1:0]      rd_idx;

  logic                  bank_we    [2];
  logic [IDX_W-1:0]      bank_waddr [2];
  logic [DATA_WIDTH-1:0] bank_wdata [2];

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  assign wr_in_range = {1'b0, write_addr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, read_addr} < DEPTH_EXT;
  assign rd_idx      = read_addr[IDX_W-1:0];

  assign clear_done  = (state == CLEAN);
  assign ready       = (state != INIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT;
      sweep       <= '0;
      active_bank <= 1'b0;
      pending     <= 1'b0;
      swap_ack    <= 1'b0;
    end else begin
      state       <= state_next;
      sweep       <= sweep_next;
      active_bank <= active_next;
      pending     <= pending_next;
      swap_ack    <= ack_next;
    end
  end

  // A swap is only taken from CLEAN, so the last sweep write always lands before the bank flips.
  always_comb begin
    state_next   = state;
    sweep_next   = sweep;
    active_next  = active_bank;
    pending_next = pending;
    ack_next     = 1'b0;
    case (state)
      INIT: begin
        if (sweep == LAST_ADDR) begin
          state_next = CLEAN;
          sweep_next = '0;
        end else begin
          sweep_next = sweep + ADDR_WIDTH'(1);
        end
      end
      CLEARING: begin
        if (swap_req) begin
          pending_next = 1'b1;
        end
        if (sweep == LAST_ADDR) begin
          state_next = CLEAN;
          sweep_next = '0;
        end else begin
          sweep_next = sweep + ADDR_WIDTH'(1);
        end
      end
      CLEAN: begin
        sweep_next = '0;
        if (swap_req || pending) begin
          active_next  = ~active_bank;
          ack_next     = 1'b1;
          pending_next = 1'b0;
          state_next   = CLEARING;
        end
      end
      default: begin
        state_next = INIT;
        sweep_next = '0;
      end
    endcase
  end

  // Sweep writes hit the shadow bank and user writes hit the active bank, so they never collide.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_we[b]    = 1'b0;
      bank_waddr[b] = sweep[IDX_W-1:0];
      bank_wdata[b] = CLEAR_VALUE;
      if (state == INIT) begin
        bank_we[b] = 1'b1;
      end else if (1'(b) != active_bank) begin
        bank_we[b] = (state == CLEARING);
      end else if (we && wr_in_range) begin
        bank_we[b]    = 1'b1;
        bank_waddr[b] = write_addr[IDX_W-1:0];
        bank_wdata[b] = write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bank_we[0]) begin
      mem0[bank_waddr[0]] <= bank_wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (bank_we[1]) begin
      mem1[bank_waddr[1]] <= bank_wdata[1];
    end
  end

  // Registered read samples the old contents on a same-address write (read-first).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data <= CLEAR_VALUE;
    end else if ((state == INIT) || !rd_in_range) begin
      read_data <= CLEAR_VALUE;
    end else if (active_bank) begin
      read_data <= mem1[rd_idx];
    end else begin
      read_data <= mem0[rd_idx];
    end
  end

endmodule

// File: tb/tb_double_buffer_clear_ram.sv
// Directed bench for double_buffer_clear_ram: init sweep, read/write, swaps,
// coalesced swap requests, swap-edge writes, out-of-range access and mid-sweep reset.
module tb_double_buffer_clear_ram;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       we;
  logic [4:0] write_addr;
  logic [3:0] write_data;
  logic [4:0] read_addr;
  logic [3:0] read_data;
  logic       swap_req;
  logic       swap_ack;
  logic       active_bank;
  logic       clear_done;
  logic       ready;

  int checks   = 0;
  int failures = 0;

  double_buffer_clear_ram #(
    .DATA_WIDTH (4),
    .DEPTH      (16),
    .ADDR_WIDTH (5),
    .CLEAR_VALUE(4'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (we),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .active_bank(active_bank),
    .clear_done (clear_done),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [3:0] d);
    read_addr = a;
    tick();
    d = read_data;
  endtask

  task automatic wait_clean(input int budget);
    int n;
    n = 0;
    while (clear_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (clear_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wait_clean: clear_done=%b after %0d cycles, required 1", clear_done, n);
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    we         = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_addr  = '0;
    swap_req   = 1'b0;
    tick();
    tick();
    checks++; if (ready !== 1'b0)       begin failures++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
    checks++; if (clear_done !== 1'b0)  begin failures++; $display("[TB] FAIL reset_clear_done: got %b want 0", clear_done); end
    checks++; if (active_bank !== 1'b0) begin failures++; $display("[TB] FAIL reset_active_bank: got %b want 0", active_bank); end
    checks++; if (swap_ack !== 1'b0)    begin failures++; $display("[TB] FAIL reset_swap_ack: got %b want 0", swap_ack); end
    checks++; if (read_data !== 4'h0)   begin failures++; $display("[TB] FAIL reset_read_data: got %h want 0", read_data); end
    // Release with a write and a swap request held through INIT; both must be ignored.
    reset_n    = 1'b1;
    we         = 1'b1;
    write_addr = 5'd4;
    write_data = 4'hF;
    swap_req   = 1'b1;
    read_addr  = 5'd4;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (ready !== 1'(k == 16)) begin
        failures++;
        $display("[TB] FAIL init_ready cycle %0d: got %b want %b", k, ready, (k == 16));
      end
      checks++;
      if (read_data !== 4'h0) begin
        failures++;
        $display("[TB] FAIL init_read_data cycle %0d: got %h want 0", k, read_data);
      end
    end
    we       = 1'b0;
    swap_req = 1'b0;
    checks++; if (clear_done !== 1'b1)  begin failures++; $display("[TB] FAIL init_clear_done: got %b want 1", clear_done); end
    checks++; if (active_bank !== 1'b0) begin failures++; $display("[TB] FAIL init_active_bank: got %b want 0", active_bank); end
    checks++; if (swap_ack !== 1'b0)    begin failures++; $display("[TB] FAIL init_swap_ack: got %b want 0", swap_ack); end
  endtask

  task automatic test_reads_clean();
    logic [3:0] d;
    for (int a = 0; a < 16; a++) begin
      do_read(5'(a), d);
      checks++;
      if (d !== 4'h0) begin
        failures++;
        $display("[TB] FAIL clean_read addr %0d: got %h want 0", a, d);
      end
    end
  endtask

  task automatic test_write_read();
    logic [3:0] d;
    we = 1'b1; write_addr = 5'd3; write_data = 4'hA; read_addr = 5'd0;
    tick();
    we = 1'b0;
    do_read(5'd3, d);
    checks++; if (d !== 4'hA) begin failures++; $display("[TB] FAIL write_read addr3: got %h want a", d); end
    we = 1'b1; write_addr = 5'd5; write_data = 4'h7; read_addr = 5'd5;
    tick();
    we = 1'b0;
    checks++; if (read_data !== 4'h0) begin failures++; $display("[TB] FAIL read_first_old: got %h want 0", read_data); end
    tick();
    checks++; if (read_data !== 4'h7) begin failures++; $display("[TB] FAIL read_first_new: got %h want 7", read_data); end
  endtask

  task automatic test_swap();
    logic [3:0] d;
    read_addr = 5'd3;
    swap_req  = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++; if (swap_ack !== 1'b1)    begin failures++; $display("[TB] FAIL swap1_ack: got %b want 1", swap_ack); end
    checks++; if (active_bank !== 1'b1) begin failures++; $display("[TB] FAIL swap1_active: got %b want 1", active_bank); end
    checks++; if (clear_done !== 1'b0)  begin failures++; $display("[TB] FAIL swap1_clear_done: got %b want 0", clear_done); end
    checks++; if (read_data !== 4'hA)   begin failures++; $display("[TB] FAIL read_at_swap_edge: got %h want a", read_data); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (clear_done !== 1'(k == 16)) begin
        failures++;
        $display("[TB] FAIL clearing_done cycle %0d: got %b want %b", k, clear_done, (k == 16));
      end
      if (k == 1) begin
        checks++; if (swap_ack !== 1'b0)  begin failures++; $display("[TB] FAIL swap1_ack_pulse: got %b want 0", swap_ack); end
        checks++; if (read_data !== 4'h0) begin failures++; $display("[TB] FAIL bank1_addr3: got %h want 0", read_data); end
      end
    end
    we = 1'b1; write_addr = 5'd3; write_data = 4'hB;
    tick();
    we = 1'b0;
    do_read(5'd3, d);
    checks++; if (d !== 4'hB) begin failures++; $display("[TB] FAIL bank1_write: got %h want b", d); end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++; if (swap_ack !== 1'b1)    begin failures++; $display("[TB] FAIL swap2_ack: got %b want 1", swap_ack); end
    checks++; if (active_bank !== 1'b0) begin failures++; $display("[TB] FAIL swap2_active: got %b want 0", active_bank); end
    tick();
    checks++; if (read_data !== 4'h0) begin failures++; $display("[TB] FAIL bank0_cleared addr3: got %h want 0", read_data); end
    wait_clean(20);
  endtask

  task automatic test_coalesce();
    int ack_cnt, ack_cyc, done_cnt, done_cyc;
    ack_cnt = 0; ack_cyc = 0; done_cnt = 0; done_cyc = 0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++; if (swap_ack !== 1'b1)    begin failures++; $display("[TB] FAIL coalesce_first_ack: got %b want 1", swap_ack); end
    checks++; if (active_bank !== 1'b1) begin failures++; $display("[TB] FAIL coalesce_first_active: got %b want 1", active_bank); end
    for (int k = 1; k <= 40; k++) begin
      swap_req = (k == 2 || k == 5 || k == 9);
      tick();
      if (swap_ack === 1'b1) begin
        ack_cnt++;
        ack_cyc = k;
      end
      if (clear_done === 1'b1 && k <= 32) begin
        done_cnt++;
        done_cyc = k;
      end
    end
    swap_req = 1'b0;
    checks++; if (ack_cnt != 1)  begin failures++; $display("[TB] FAIL coalesce_ack_count: got %0d want 1", ack_cnt); end
    checks++; if (ack_cyc != 17) begin failures++; $display("[TB] FAIL coalesce_ack_cycle: got %0d want 17", ack_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL coalesce_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_cyc != 16) begin failures++; $display("[TB] FAIL coalesce_done_cycle: got %0d want 16", done_cyc); end
    checks++; if (active_bank !== 1'b0) begin failures++; $display("[TB] FAIL coalesce_active: got %b want 0", active_bank); end
    checks++; if (clear_done !== 1'b1)  begin failures++; $display("[TB] FAIL coalesce_settled: got %b want 1", clear_done); end
  endtask

  task automatic test_swap_edge_write();
    logic [3:0] d;
    swap_req = 1'b1; we = 1'b1; write_addr = 5'd2; write_data = 4'h9;
    tick();
    swap_req = 1'b0; we = 1'b0;
    checks++; if (swap_ack !== 1'b1) begin failures++; $display("[TB] FAIL edge_write_ack: got %b want 1", swap_ack); end
    do_read(5'd2, d);
    checks++; if (d !== 4'h0) begin failures++; $display("[TB] FAIL edge_write_bank1: got %h want 0", d); end
    wait_clean(20);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++; if (active_bank !== 1'b0) begin failures++; $display("[TB] FAIL edge_write_swap_back: got %b want 0", active_bank); end
    do_read(5'd2, d);
    checks++; if (d !== 4'h0) begin failures++; $display("[TB] FAIL edge_write_bank0: got %h want 0", d); end
    wait_clean(20);
    we = 1'b1; write_addr = 5'd0; write_data = 4'h6;
    tick();
    write_addr = 5'd16; write_data = 4'h5;
    tick();
    we = 1'b0;
    do_read(5'd16, d);
    checks++; if (d !== 4'h0) begin failures++; $display("[TB] FAIL out_of_range_read: got %h want 0", d); end
    do_read(5'd0, d);
    checks++; if (d !== 4'h6) begin failures++; $display("[TB] FAIL out_of_range_alias: got %h want 6", d); end
  endtask

  task automatic test_reset_midsweep();
    logic [3:0] d;
    we = 1'b1; write_addr = 5'd6; write_data = 4'hC;
    tick();
    we = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    we = 1'b1; write_addr = 5'd6; write_data = 4'hD; read_addr = 5'd6;
    tick();
    we = 1'b0;
    for (int k = 2; k <= 7; k++) tick();
    checks++; if (read_data !== 4'hD)   begin failures++; $display("[TB] FAIL pre_reset_read: got %h want d", read_data); end
    checks++; if (active_bank !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_active: got %b want 1", active_bank); end
    reset_n = 1'b0;
    #1;
    checks++; if (active_bank !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_active: got %b want 0", active_bank); end
    checks++; if (swap_ack !== 1'b0)    begin failures++; $display("[TB] FAIL async_reset_ack: got %b want 0", swap_ack); end
    checks++; if (clear_done !== 1'b0)  begin failures++; $display("[TB] FAIL async_reset_done: got %b want 0", clear_done); end
    checks++; if (ready !== 1'b0)       begin failures++; $display("[TB] FAIL async_reset_ready: got %b want 0", ready); end
    checks++; if (read_data !== 4'h0)   begin failures++; $display("[TB] FAIL async_reset_read: got %h want 0", read_data); end
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (ready !== 1'(k == 16)) begin
        failures++;
        $display("[TB] FAIL reinit_ready cycle %0d: got %b want %b", k, ready, (k == 16));
      end
      checks++;
      if (read_data !== 4'h0) begin
        failures++;
        $display("[TB] FAIL reinit_read cycle %0d: got %h want 0", k, read_data);
      end
    end
    checks++; if (active_bank !== 1'b0) begin failures++; $display("[TB] FAIL reinit_active: got %b want 0", active_bank); end
    for (int a = 0; a < 16; a++) begin
      do_read(5'(a), d);
      checks++;
      if (d !== 4'h0) begin
        failures++;
        $display("[TB] FAIL reinit_bank0 addr %0d: got %h want 0", a, d);
      end
    end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    do_read(5'd6, d);
    checks++; if (d !== 4'h0) begin failures++; $display("[TB] FAIL reinit_bank1 addr6: got %h want 0", d); end
    wait_clean(20);
  endtask

  initial begin
    test_reset();
    test_reads_clean();
    test_write_read();
    test_swap();
    test_coalesce();
    test_swap_edge_write();
    test_reset_midsweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
